sprite_compositor: RTL
======================

Name: sprite_compositor

Overview:
Parametrised N-channel sprite overlay stage for the 1024x768 VGA pipeline. It generalises the per-player draw stages into one block with per-channel ROM address generation, frame-latched positions, transparency keying, fixed priority and per-channel hit-flash blinking. It takes timing plus rgb from the upstream stage, and drives synchronous sprite ROMs with 1-cycle read latency. It emits composited timing and rgb to the next stage.

Parameters:
N_SPR, 4, number of sprite channels (1..8)
SPR_W, 128, sprite width in pixels (power of two)
SPR_H, 128, sprite height in pixels
ADDR_W, 14, ROM address width per channel
KEY_RGB, 12'h0F0, transparent colour
FLASH_FRAMES, 32, frames a channel blinks after a hit
FLASH_PERIOD, 4, frames per blink half-period (power of two)

Ports:
clk  in  1  pixel clock, 65 MHz
rst  in  1  reset, asynchronous, active-high
vcount_in  in  11  vertical counter
hcount_in  in  11  horizontal counter
vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  timing
rgb_in  in  12  upstream pixel
spr_en  in  N_SPR  channel enable
spr_x  in  N_SPR*11  left edge, channel i at [11i+:11]
spr_y  in  N_SPR*11  top edge
hit  in  N_SPR  one-cycle hit pulse per channel
rom_addr  out  N_SPR*ADDR_W  ROM address per channel
rom_rgb  in  N_SPR*12  ROM data, valid 1 cycle after rom_addr
vcount_out, hcount_out  out  11 each  delayed counters
vsync_out, hsync_out, vblnk_out, hblnk_out  out  1 each  delayed timing
rgb_out  out  12  composited pixel
flash_active  out  N_SPR  channel currently blinking

Behaviour:
- Reset: all outputs 0. Shadow enable/x/y are 0. Flash counters are 0. Pipeline registers are 0.
- Frame latch: vsync_in is registered, and its rising edge is frame_tick. On frame_tick, spr_en/x/y are copied into shadow registers. Drawing uses only the shadows, so there is no mid-frame tearing.
- After reset, nothing is drawn until the first frame_tick.
- Stage 1 (t+1): for each channel compute in_box = shadow_en & ~hblnk_in & ~vblnk_in & hcount_in>=x & hcount_in<x+SPR_W & vcount_in>=y & vcount_in<y+SPR_H.
  - Compare in 12 bits; no wrap, so sprites are clipped at screen edges.
  - rom_addr = (vcount_in-y)*SPR_W + (hcount_in-x), truncated to ADDR_W. rom_addr is 0 when not in_box. in_box is registered.
- Stage 2 (t+2): rom_rgb is valid. in_box is delayed one more cycle.
- Stage 3 (t+3): outputs registered.
  - rgb_out = rom_rgb of the lowest-index channel with in_box & rom_rgb!=KEY_RGB & visible. Otherwise rgb_in delayed 3 cycles.
  - rgb_out = 0 if the delayed hblnk or vblnk is set.
- Latency is exactly 3 cycles for every timing signal and for the rgb passthrough.
- Flash counter per channel, width clog2(FLASH_FRAMES+1):
  - hit[i] loads FLASH_FRAMES.
  - frame_tick decrements a non-zero counter.
  - hit and frame_tick in the same cycle: load wins.
  - A hit during an active flash reloads the counter.
  - flash_active[i] = counter!=0.
- visible[i] = ~flash_active[i] | ~counter[clog2(FLASH_PERIOD)]. Hidden pixels fall through to lower priority channels or to rgb_in.
- The flash counter changes only at frame_tick or on hit, so visibility is constant within a frame except on the hit cycle.
- Asynchronous reset mid-frame clears everything immediately. Outputs are black and zero timing until upstream timing propagates (3 cycles).

Test Plan:
1. N_SPR=2. Channel 0 at x=100,y=200 with ROM returning 12'hF00 everywhere; latch via vsync edge. Expect rgb_out=F00 for hcount 100..227, vcount 200..327, 3 cycles after input. Expect rgb_in elsewhere. Expect rom_addr=0 at (100,200) and 127 at (227,200).
2. Overlapping channels 0 and 1 at the same position, both opaque. Expect channel 0 colour. Set the channel 0 ROM to KEY_RGB: expect channel 1 colour. Both keyed: expect rgb_in.
3. Change spr_x mid-frame from 100 to 300. Expect the current frame still drawn at 100 and the next frame at 300.
4. Pulse hit[0]. Expect flash_active[0]=1 for exactly 32 frame_ticks. Channel 0 hidden in frames where counter bit2=1 (e.g. counters 31..28 hidden, 27..24 shown). A second hit at counter 10 reloads to 32.
5. Sprite at x=1000, width 128. Expect drawing only for hcount 1000..1023, rgb_out=0 during blanking, no wrap to hcount 0..103.
6. Assert rst mid-line. Expect all outputs 0 immediately and no sprite drawn before the next vsync rising edge. Timing passthrough recovers at 3-cycle latency.

Source files
------------

// File: rtl/sprite_compositor.sv
// N-channel sprite overlay: per-lane box test and ROM addressing, frame-latched
// positions, colour keying, fixed priority (channel 0 on top) and hit-flash blinking.

module sprite_lane #(
    parameter int SPR_W        = 128,
    parameter int SPR_H        = 128,
    parameter int ADDR_W       = 14,
    parameter int FLASH_FRAMES = 32,
    parameter int FLASH_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              hit,
    input  logic              spr_en,
    input  logic [10:0]       spr_x,
    input  logic [10:0]       spr_y,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic              hblnk,
    input  logic              vblnk,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              in_box_s2,
    output logic              visible,
    output logic              flash_active
);
    localparam int CW = $clog2(FLASH_FRAMES + 1);
    localparam int BB = $clog2(FLASH_PERIOD);
    localparam int SW = $clog2(SPR_W);
    localparam int FW = (ADDR_W > 22) ? ADDR_W : 22;

    logic          sh_en;
    logic [10:0]   sh_x, sh_y;
    logic [11:0]   hc12, vc12, x12, y12, x_end, y_end;
    logic [10:0]   dx, dy;
    logic [FW-1:0] addr_full;
    logic          in_box_c, in_box_s1;
    logic [CW-1:0] cnt;

    // Positions are only sampled at the frame boundary so a sprite never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_en <= 1'b0;
            sh_x  <= '0;
            sh_y  <= '0;
        end else if (frame_tick) begin
            sh_en <= spr_en;
            sh_x  <= spr_x;
            sh_y  <= spr_y;
        end
    end

    // 12-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
    always_comb begin
        hc12  = {1'b0, hcount};
        vc12  = {1'b0, vcount};
        x12   = {1'b0, sh_x};
        y12   = {1'b0, sh_y};
        x_end = x12 + 12'(SPR_W);
        y_end = y12 + 12'(SPR_H);
        in_box_c = sh_en & ~hblnk & ~vblnk &
                   (hc12 >= x12) & (hc12 < x_end) &
                   (vc12 >= y12) & (vc12 < y_end);
        dx = hcount - sh_x;
        dy = vcount - sh_y;
        addr_full = (FW'(dy) << SW) + FW'(dx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_box_s1 <= 1'b0;
            in_box_s2 <= 1'b0;
            rom_addr  <= '0;
        end else begin
            in_box_s1 <= in_box_c;
            in_box_s2 <= in_box_s1;
            rom_addr  <= in_box_c ? addr_full[ADDR_W-1:0] : '0;
        end
    end

    // A hit (re)loads the counter and wins over a coincident frame tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (hit)
            cnt <= CW'(FLASH_FRAMES);
        else if (frame_tick && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign flash_active = (cnt != '0);
    assign visible      = ~flash_active | ~cnt[BB];
endmodule

module sprite_compositor #(
    parameter int          N_SPR        = 4,
    parameter int          SPR_W        = 128,
    parameter int          SPR_H        = 128,
    parameter int          ADDR_W       = 14,
    parameter logic [11:0] KEY_RGB      = 12'h0F0,
    parameter int          FLASH_FRAMES = 32,
    parameter int          FLASH_PERIOD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [10:0]             vcount_in,
    input  logic [10:0]             hcount_in,
    input  logic                    vsync_in,
    input  logic                    hsync_in,
    input  logic                    vblnk_in,
    input  logic                    hblnk_in,
    input  logic [11:0]             rgb_in,
    input  logic [N_SPR-1:0]        spr_en,
    input  logic [N_SPR*11-1:0]     spr_x,
    input  logic [N_SPR*11-1:0]     spr_y,
    input  logic [N_SPR-1:0]        hit,
    output logic [N_SPR*ADDR_W-1:0] rom_addr,
    input  logic [N_SPR*12-1:0]     rom_rgb,
    output logic [10:0]             vcount_out,
    output logic [10:0]             hcount_out,
    output logic                    vsync_out,
    output logic                    hsync_out,
    output logic                    vblnk_out,
    output logic                    hblnk_out,
    output logic [11:0]             rgb_out,
    output logic [N_SPR-1:0]        flash_active
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        hsync;
        logic        vblnk;
        logic        hblnk;
    } tim_t;

    tim_t        tim_pipe [STAGES:0];
    logic [11:0] rgb_pipe [2:1];
    logic [11:0] rgb_q, pix_nxt;
    logic        frame_tick;
    logic [N_SPR-1:0] in_box_s2, visible;

    always_comb begin
        tim_pipe[0] = '{vcount: vcount_in, hcount: hcount_in, vsync: vsync_in,
                        hsync: hsync_in, vblnk: vblnk_in, hblnk: hblnk_in};
    end

    // Stage 1 vsync doubles as the edge detector's history bit.
    assign frame_tick = vsync_in & ~tim_pipe[1].vsync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) tim_pipe[k] <= '0;
            rgb_pipe[1] <= '0;
            rgb_pipe[2] <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) tim_pipe[k] <= tim_pipe[k-1];
            rgb_pipe[1] <= rgb_in;
            rgb_pipe[2] <= rgb_pipe[1];
        end
    end

    for (genvar i = 0; i < N_SPR; i++) begin : g_lane
        sprite_lane #(
            .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W),
            .FLASH_FRAMES(FLASH_FRAMES), .FLASH_PERIOD(FLASH_PERIOD)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .frame_tick   (frame_tick),
            .hit          (hit[i]),
            .spr_en       (spr_en[i]),
            .spr_x        (spr_x[11*i +: 11]),
            .spr_y        (spr_y[11*i +: 11]),
            .hcount       (hcount_in),
            .vcount       (vcount_in),
            .hblnk        (hblnk_in),
            .vblnk        (vblnk_in),
            .rom_addr     (rom_addr[ADDR_W*i +: ADDR_W]),
            .in_box_s2    (in_box_s2[i]),
            .visible      (visible[i]),
            .flash_active (flash_active[i])
        );
    end

    // Walk from the highest index down so the lowest opaque visible channel wins.
    always_comb begin
        pix_nxt = rgb_pipe[2];
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (in_box_s2[i] && visible[i] && rom_rgb[12*i +: 12] != KEY_RGB)
                pix_nxt = rom_rgb[12*i +: 12];
        end
        if (tim_pipe[2].hblnk || tim_pipe[2].vblnk)
            pix_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb_q <= '0;
        else     rgb_q <= pix_nxt;
    end

    assign vcount_out = tim_pipe[STAGES].vcount;
    assign hcount_out = tim_pipe[STAGES].hcount;
    assign vsync_out  = tim_pipe[STAGES].vsync;
    assign hsync_out  = tim_pipe[STAGES].hsync;
    assign vblnk_out  = tim_pipe[STAGES].vblnk;
    assign hblnk_out  = tim_pipe[STAGES].hblnk;
    assign rgb_out    = rgb_q;
endmodule
